// File: rtl/pcie_ebuf_pkg.sv
// pcie_ebuf_pkg: shared fetch FSM encoding, descriptor layout and fetch batch size
package pcie_ebuf_pkg;
  localparam int BATCH = 8;
  localparam int DESC_W = 96;
  localparam int ID_LSB = 80;
  localparam int SIZE_LSB = 64;
  localparam int ADDR_LSB = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_ACK} fetch_st_e;
endpackage

// File: rtl/pcie_ebuf_fifo.sv
// pcie_ebuf_fifo: DEPTH x 96 descriptor FIFO with async read head, occupancy count and full/empty
module pcie_ebuf_fifo
  import pcie_ebuf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DESC_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DESC_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   cnt_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int CW = ADDR_W + 1;
  logic [DESC_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  // storage array has no reset; resetting the pointers discards its contents
  always_ff @(posedge clk_i)
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  // pointers wrap modulo DEPTH; count moves by +1, -1 or 0
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      cnt_q <= cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
    end
  assign rd_data_o = mem_q[rd_ptr_q];
  assign cnt_o = cnt_q;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/pcie_up_ebuf_mgr.sv
// pcie_up_ebuf_mgr: buffers upstream empty-buffer descriptors and paces batch fetch requests by free space
module pcie_up_ebuf_mgr
  import pcie_ebuf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter int TMO_CYC = 65535
) (
  input  logic              PCIE_CLK,
  input  logic              PCIE_RST_N,
  input  logic              UP_EBUF_WR_REQ,
  input  logic [95:0]       UP_EBUF_WR_DATA,
  input  logic              UP_EBUF_RD_REQ,
  input  logic              UP_EBUF_RD_ACK,
  input  logic              EBUF_KICK,
  output logic              EBUF_VLD,
  output logic [15:0]       EBUF_ID,
  output logic [15:0]       EBUF_SIZE,
  output logic [63:0]       EBUF_ADDR,
  input  logic              EBUF_POP,
  output logic              EBUF_FETCH_REQ,
  input  logic              EBUF_FETCH_GNT,
  output logic [ADDR_W:0]   EBUF_CNT,
  output logic              EBUF_OVF,
  output logic              EBUF_TMO
);
  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(TMO_CYC + 1);
  fetch_st_e st_q;
  logic [TW-1:0] tmr_q;
  logic pend_q, pend_d, req_q, ovf_q, tmo_q;
  logic full, empty, pop_v, wr_ok, space_ok, tmo_hit, pend_set;
  logic [DESC_W-1:0] head;
  assign pop_v = EBUF_POP & ~empty;
  assign wr_ok = UP_EBUF_WR_REQ & (~full | pop_v);
  assign space_ok = EBUF_CNT <= CW'(DEPTH - BATCH);
  assign tmo_hit = (st_q == ST_WAIT_ACK) & ~UP_EBUF_RD_ACK & (tmr_q == TW'(TMO_CYC - 1));
  assign pend_set = EBUF_KICK | (UP_EBUF_RD_ACK & UP_EBUF_RD_REQ) | tmo_hit;
  assign pend_d = pend_set | (pend_q & ~EBUF_FETCH_GNT);
  pcie_ebuf_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk_i(PCIE_CLK),
    .rst_ni(PCIE_RST_N),
    .wr_en_i(wr_ok),
    .wr_data_i(UP_EBUF_WR_DATA),
    .rd_en_i(pop_v),
    .rd_data_o(head),
    .cnt_o(EBUF_CNT),
    .full_o(full),
    .empty_o(empty)
  );
  // pending request flag plus sticky overflow and timeout flags
  always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N)
    if (!PCIE_RST_N) begin
      pend_q <= 1'b0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (UP_EBUF_WR_REQ & ~wr_ok) ovf_q <= 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  // fetch FSM: one batch in flight, requested only when a whole batch fits
  always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N)
    if (!PCIE_RST_N) begin
      st_q <= ST_IDLE;
      req_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      case (st_q)
        ST_IDLE:
          if (pend_q & space_ok) begin
            st_q <= ST_REQ;
            req_q <= 1'b1;
          end
        ST_REQ:
          if (EBUF_FETCH_GNT) begin
            st_q <= ST_WAIT_ACK;
            req_q <= 1'b0;
            tmr_q <= '0;
          end
        ST_WAIT_ACK:
          if (UP_EBUF_RD_ACK | tmo_hit) st_q <= ST_IDLE;
          else tmr_q <= tmr_q + TW'(1);
        default: st_q <= ST_IDLE;
      endcase
    end
  assign EBUF_VLD = ~empty;
  assign EBUF_ID = head[ID_LSB +: 16];
  assign EBUF_SIZE = head[SIZE_LSB +: 16];
  assign EBUF_ADDR = head[ADDR_LSB +: 64];
  assign EBUF_FETCH_REQ = req_q;
  assign EBUF_OVF = ovf_q;
  assign EBUF_TMO = tmo_q;
endmodule

// File: tb/tb_pcie_up_ebuf_mgr.sv
// tb_pcie_up_ebuf_mgr: directed scoreboard bench for the upstream empty-buffer manager
module tb_pcie_up_ebuf_mgr;
  logic PCIE_CLK = 1'b0;
  logic PCIE_RST_N = 1'b0;
  logic UP_EBUF_WR_REQ = 1'b0;
  logic [95:0] UP_EBUF_WR_DATA = '0;
  logic UP_EBUF_RD_REQ = 1'b0;
  logic UP_EBUF_RD_ACK = 1'b0;
  logic EBUF_KICK = 1'b0;
  logic EBUF_POP = 1'b0;
  logic EBUF_FETCH_GNT = 1'b0;
  logic EBUF_VLD, EBUF_FETCH_REQ, EBUF_OVF, EBUF_TMO;
  logic [15:0] EBUF_ID, EBUF_SIZE;
  logic [63:0] EBUF_ADDR;
  logic [6:0] EBUF_CNT;
  logic [95:0] sb[$];
  int m_cnt = 0;
  int passed = 0;
  int total = 0;
  int fails = 0;
  logic [15:0] nid = '0;

  pcie_up_ebuf_mgr #(.DEPTH(64), .ADDR_W(6), .TMO_CYC(16)) dut (
    .PCIE_CLK(PCIE_CLK),
    .PCIE_RST_N(PCIE_RST_N),
    .UP_EBUF_WR_REQ(UP_EBUF_WR_REQ),
    .UP_EBUF_WR_DATA(UP_EBUF_WR_DATA),
    .UP_EBUF_RD_REQ(UP_EBUF_RD_REQ),
    .UP_EBUF_RD_ACK(UP_EBUF_RD_ACK),
    .EBUF_KICK(EBUF_KICK),
    .EBUF_VLD(EBUF_VLD),
    .EBUF_ID(EBUF_ID),
    .EBUF_SIZE(EBUF_SIZE),
    .EBUF_ADDR(EBUF_ADDR),
    .EBUF_POP(EBUF_POP),
    .EBUF_FETCH_REQ(EBUF_FETCH_REQ),
    .EBUF_FETCH_GNT(EBUF_FETCH_GNT),
    .EBUF_CNT(EBUF_CNT),
    .EBUF_OVF(EBUF_OVF),
    .EBUF_TMO(EBUF_TMO)
  );

  always #5 PCIE_CLK = ~PCIE_CLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCIE_CLK);
    #1;
  endtask

  task automatic pulse_step(input logic kick, input logic ack, input logic rreq, input logic gnt);
    EBUF_KICK = kick;
    UP_EBUF_RD_ACK = ack;
    UP_EBUF_RD_REQ = rreq;
    EBUF_FETCH_GNT = gnt;
    step();
    EBUF_KICK = 1'b0;
    UP_EBUF_RD_ACK = 1'b0;
    UP_EBUF_RD_REQ = 1'b0;
    EBUF_FETCH_GNT = 1'b0;
  endtask

  // one clock of write and/or pop; the scoreboard decides acceptance and checks the head on each pop
  task automatic cyc(input logic wr, input logic pop);
    logic [95:0] d;
    logic pv, acc;
    d = {nid, nid ^ 16'h00F0, 32'hA5A5_0000, 16'h0000, nid};
    UP_EBUF_WR_REQ = wr;
    UP_EBUF_WR_DATA = d;
    EBUF_POP = pop;
    pv = pop && m_cnt > 0;
    acc = wr && (m_cnt < 64 || pv);
    if (pv) begin
      chk("head", {EBUF_ID, EBUF_SIZE, EBUF_ADDR}, sb[0]);
      void'(sb.pop_front());
    end
    if (acc) sb.push_back(d);
    if (wr) nid++;
    m_cnt = m_cnt + int'(acc) - int'(pv);
    step();
    UP_EBUF_WR_REQ = 1'b0;
    EBUF_POP = 1'b0;
  endtask

  initial begin
    step();
    chk("rst_vld", 96'(EBUF_VLD), 96'd0);
    chk("rst_cnt", 96'(EBUF_CNT), 96'd0);
    chk("rst_req", 96'(EBUF_FETCH_REQ), 96'd0);
    chk("rst_ovf", 96'(EBUF_OVF), 96'd0);
    chk("rst_tmo", 96'(EBUF_TMO), 96'd0);
    #2 PCIE_RST_N = 1'b1;
    step();
    // kick, grant after 3 cycles of request, batch of 8, ack without more pending
    pulse_step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("kick_req_n", 96'(EBUF_FETCH_REQ), 96'd0);
    step();
    chk("kick_req_n1", 96'(EBUF_FETCH_REQ), 96'd1);
    step();
    step();
    chk("req_held", 96'(EBUF_FETCH_REQ), 96'd1);
    pulse_step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("gnt_drop", 96'(EBUF_FETCH_REQ), 96'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
    pulse_step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("batch_cnt", 96'(EBUF_CNT), 96'd8);
    chk("batch_vld", 96'(EBUF_VLD), 96'd1);
    step();
    step();
    chk("no_req", 96'(EBUF_FETCH_REQ), 96'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
    chk("drain_vld", 96'(EBUF_VLD), 96'd0);
    // space check at 56 entries: request two cycles after ack
    for (int i = 0; i < 56; i++) cyc(1'b1, 1'b0);
    chk("cnt56", 96'(EBUF_CNT), 96'd56);
    pulse_step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("c56_req_n", 96'(EBUF_FETCH_REQ), 96'd0);
    step();
    chk("c56_req_n1", 96'(EBUF_FETCH_REQ), 96'd1);
    pulse_step(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_step(1'b0, 1'b1, 1'b0, 1'b0);
    // 57 entries: held off until one pop frees a batch of space
    cyc(1'b1, 1'b0);
    pulse_step(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("c57_held", 96'(EBUF_FETCH_REQ), 96'd0);
    cyc(1'b0, 1'b1);
    chk("c57_pop_n", 96'(EBUF_FETCH_REQ), 96'd0);
    step();
    chk("c57_pop_n1", 96'(EBUF_FETCH_REQ), 96'd1);
    pulse_step(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_step(1'b0, 1'b1, 1'b0, 1'b0);
    // full FIFO: drop on plain write, accept with simultaneous pop
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
    chk("full_cnt", 96'(EBUF_CNT), 96'd64);
    chk("full_ovf0", 96'(EBUF_OVF), 96'd0);
    cyc(1'b1, 1'b0);
    chk("drop_ovf", 96'(EBUF_OVF), 96'd1);
    chk("drop_cnt", 96'(EBUF_CNT), 96'd64);
    cyc(1'b1, 1'b1);
    chk("wrpop_full_cnt", 96'(EBUF_CNT), 96'd64);
    chk("wrpop_full_ovf", 96'(EBUF_OVF), 96'd1);
    // drain to one, then write and pop together
    for (int i = 0; i < 63; i++) cyc(1'b0, 1'b1);
    chk("one_cnt", 96'(EBUF_CNT), 96'd1);
    cyc(1'b1, 1'b1);
    chk("wrpop1_cnt", 96'(EBUF_CNT), 96'd1);
    chk("wrpop1_vld", 96'(EBUF_VLD), 96'd1);
    chk("wrpop1_head", {EBUF_ID, EBUF_SIZE, EBUF_ADDR}, sb[0]);
    cyc(1'b0, 1'b1);
    chk("empty_vld", 96'(EBUF_VLD), 96'd0);
    // timeout 16 cycles after the grant edge, then request reasserts
    pulse_step(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("tmo_req", 96'(EBUF_FETCH_REQ), 96'd1);
    pulse_step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step();
    chk("tmo_early", 96'(EBUF_TMO), 96'd0);
    step();
    chk("tmo_set", 96'(EBUF_TMO), 96'd1);
    step();
    chk("tmo_rereq", 96'(EBUF_FETCH_REQ), 96'd1);
    // asynchronous reset in WAIT_ACK with 5 entries
    pulse_step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    chk("pre_rst_cnt", 96'(EBUF_CNT), 96'd5);
    #2 PCIE_RST_N = 1'b0;
    #1;
    chk("arst_vld", 96'(EBUF_VLD), 96'd0);
    chk("arst_cnt", 96'(EBUF_CNT), 96'd0);
    chk("arst_req", 96'(EBUF_FETCH_REQ), 96'd0);
    chk("arst_ovf", 96'(EBUF_OVF), 96'd0);
    chk("arst_tmo", 96'(EBUF_TMO), 96'd0);
    #2 PCIE_RST_N = 1'b1;
    sb.delete();
    m_cnt = 0;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_no_req", 96'(EBUF_FETCH_REQ), 96'd0);
    pulse_step(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_rst_kick_req", 96'(EBUF_FETCH_REQ), 96'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pcie_up_ebuf_mgr.md
# pcie_up_ebuf_mgr

Upstream empty-buffer descriptor manager. Consumes the 96-bit descriptors {buffer ID, size, address} and read-request/read-ack strobes produced by the PCIe descriptor-completion extractor (`PCIE_DN_CPLD_UEK`, downstream CPLD path), and stores the descriptors in a local FIFO. It presents them to the upstream DMA engine through a valid/pop interface. It also paces descriptor-fetch requests to the PCIe read-request generator by free FIFO space and per-batch acknowledgement.

## Interface
Parameters:
- DEPTH, 64, FIFO entries; power of two, ≥ 16
- ADDR_W, 6, log2(DEPTH)
- BATCH, 8, descriptors returned per fetch; fixed by the extractor, not to be overridden
- TMO_CYC, 65535, max cycles in WAIT_ACK before timeout

Ports:
- PCIE_CLK  in  1  clock; single clock domain
- PCIE_RST_N  in  1  reset; asynchronous assert, active-low
- UP_EBUF_WR_REQ  in  1  descriptor write strobe, one cycle per descriptor
- UP_EBUF_WR_DATA  in  96  [95:80] ID, [79:64] size, [63:0] address
- UP_EBUF_RD_REQ  in  1  host reports more descriptors pending; only meaningful with RD_ACK
- UP_EBUF_RD_ACK  in  1  end of a BATCH-descriptor fetch
- EBUF_KICK  in  1  doorbell pulse: descriptors available
- EBUF_VLD  out  1  head descriptor valid
- EBUF_ID  out  16  head ID
- EBUF_SIZE  out  16  head size
- EBUF_ADDR  out  64  head address
- EBUF_POP  in  1  consume head; ignored when EBUF_VLD=0
- EBUF_FETCH_REQ  out  1  request one BATCH fetch; level, held until grant
- EBUF_FETCH_GNT  in  1  fetch accepted by read-request generator
- EBUF_CNT  out  ADDR_W+1  FIFO occupancy
- EBUF_OVF  out  1  sticky: descriptor dropped (FIFO full)
- EBUF_TMO  out  1  sticky: fetch timeout

## Operation
- FIFO write: on UP_EBUF_WR_REQ, store the descriptor at wr_ptr. Accept when EBUF_CNT<DEPTH, or when EBUF_CNT=DEPTH and a valid pop occurs in the same cycle. Otherwise drop and set EBUF_OVF.
- Pop: EBUF_POP & EBUF_VLD advances rd_ptr.
- EBUF_CNT updates +1, −1, or 0 on simultaneous accepted write and pop.
- Pointers are ADDR_W bits and wrap naturally modulo DEPTH.
- Pending flag:
  - Set by EBUF_KICK.
  - Set by UP_EBUF_RD_ACK & UP_EBUF_RD_REQ.
  - Cleared on the EBUF_FETCH_GNT cycle.
  - If set and cleared in the same cycle, set wins.
- Fetch FSM:
  - IDLE → REQ when pending=1 and DEPTH−EBUF_CNT ≥ BATCH.
  - REQ: EBUF_FETCH_REQ=1. On EBUF_FETCH_GNT → WAIT_ACK, clear timer.
  - WAIT_ACK: timer increments each cycle. On UP_EBUF_RD_ACK → IDLE.
  - WAIT_ACK timeout: when timer = TMO_CYC−1 without ack, set EBUF_TMO, set pending, → IDLE.
  - RD_ACK outside WAIT_ACK is ignored by the FSM, but its RD_REQ still sets pending.
- Only one fetch is in flight at a time. The space check in IDLE therefore guarantees no overflow in normal operation.
- Reset mid-operation: all state returns to reset values immediately. FIFO contents are discarded. Pending is cleared.

## Timing
- Reset values:
  - EBUF_VLD=0, EBUF_CNT=0, EBUF_FETCH_REQ=0, EBUF_OVF=0, EBUF_TMO=0.
  - EBUF_ID, EBUF_SIZE, EBUF_ADDR are don't-care while EBUF_VLD=0.
  - FSM=IDLE, pointers=0.
- Write at edge N into an empty FIFO → EBUF_VLD=1 with matching data after edge N (cycle N+1).
- Head data: asynchronous read of mem[rd_ptr]. It changes on the edge that pops.
- EBUF_VLD = (EBUF_CNT≠0), registered via EBUF_CNT.
- KICK at edge N with space available → FSM=REQ and EBUF_FETCH_REQ=1 from edge N+1. That is 2-edge latency: pending registers at edge N, FSM moves at edge N+1.
- EBUF_FETCH_REQ drops on the edge sampling EBUF_FETCH_GNT.
- RD_ACK at edge N in WAIT_ACK → IDLE after N. A new REQ can appear after N+1 if pending and space allow.

## Structure
- Shared package `pcie_ebuf_pkg`:
  - FSM state encoding (IDLE, REQ, WAIT_ACK)
  - descriptor field offsets (ID 95:80, SIZE 79:64, ADDR 63:0)
  - BATCH constant
- One sub-module, `pcie_ebuf_fifo`: parameterised DEPTH×96 distributed-RAM FIFO with async read, count, and full/empty.
- FSM, pending flag, timer and sticky flags live in the top level.

## Test plan
- Reset, KICK, GNT after 3 cycles, eight WR_REQ descriptors (ID 0..7), then RD_ACK with RD_REQ=0:
  - EBUF_CNT=8, FSM IDLE, no further REQ.
  - Popping 8 times yields IDs 0..7 in order, addresses intact.
- RD_ACK with RD_REQ=1 and EBUF_CNT=56 (DEPTH=64): REQ asserts two cycles later. Repeat with EBUF_CNT=57: REQ is held off until one pop, then asserts.
- Fill to 64, then WR_REQ with no pop: descriptor dropped, EBUF_OVF=1, EBUF_CNT stays 64. Repeat with a simultaneous pop: write accepted, EBUF_CNT stays 64, EBUF_OVF unchanged.
- Simultaneous write and pop at EBUF_CNT=1: EBUF_CNT stays 1, EBUF_VLD stays 1, and the head becomes the new descriptor.
- TMO_CYC=16, grant given, no RD_ACK:
  - EBUF_TMO=1 exactly 16 cycles after the grant edge.
  - FSM returns to IDLE and REQ reasserts.
- Assert PCIE_RST_N low while in WAIT_ACK with EBUF_CNT=5: all outputs return to reset values asynchronously. After release, no REQ until KICK.
